hazard_call_gen: RTL

- Generates the injected hazard-call instruction and the `sel` control for the fetch-stage instruction-word mux.
- Collects hazard/interrupt request pulses, prioritises them, and waits for a safe fetch slot.
- Presents a CALL-to-vector word with `sel`=1 until fetch accepts it, then blocks further injection until the handler retires its return.
- Sits in the datapath beside program memory, upstream of decode.

---
 rtl/hazard_call_gen.sv | 131 +++++++++++++
 1 files changed

// File: rtl/hazard_call_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hazard_call_gen: prioritised hazard/interrupt CALL injector for fetch mux |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module hazard_call_gen #(
  parameter int          NUM_SRC       = 8,
  parameter int          ID_W          = 3,
  parameter logic [7:0]  CALL_OPCODE   = 8'h3C,
  parameter logic [23:0] VECTOR_BASE   = 24'h000100,
  parameter logic [23:0] VECTOR_STRIDE = 24'h000004,
  parameter logic [31:0] NOP_WORD      = 32'h00000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] hazard_req,
  input  logic [NUM_SRC-1:0] hazard_mask,
  input  logic               global_en,
  input  logic               stall,
  input  logic               branch_in_flight,
  input  logic               reti,
  output logic               sel,
  output logic [31:0]        hazard_call_instruction,
  output logic               active,
  output logic [ID_W-1:0]    active_id,
  output logic [NUM_SRC-1:0] pending
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_INJECT  = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               sel_q, sel_d;
  logic [31:0]        word_q, word_d;
  logic               active_q, active_d;
  logic [ID_W-1:0]    active_id_q, active_id_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;

  logic [NUM_SRC-1:0] eligible;
  logic               has_eligible;
  logic [ID_W-1:0]    winner;
  logic [23:0]        vector_addr;
  logic [NUM_SRC-1:0] clr_mask;

  // Lowest-index eligible source wins; scanning downward leaves the lowest last.
  always_comb begin
    eligible     = pending_q & hazard_mask;
    has_eligible = |eligible;
    winner       = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) winner = ID_W'(i);
    end
    vector_addr = VECTOR_BASE + 24'(winner) * VECTOR_STRIDE;
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    word_d      = word_q;
    active_d    = active_q;
    active_id_d = active_id_q;
    clr_mask    = '0;

    case (state_q)
      ST_IDLE: begin
        if (global_en && has_eligible && !branch_in_flight) begin
          state_d     = ST_INJECT;
          sel_d       = 1'b1;
          active_d    = 1'b1;
          active_id_d = winner;
          word_d      = {CALL_OPCODE, vector_addr};
        end else begin
          sel_d  = 1'b0;
          word_d = NOP_WORD;
        end
      end
      ST_INJECT: begin
        if (!stall) begin
          clr_mask = NUM_SRC'(1) << active_id_q;
          state_d  = ST_SERVICE;
          sel_d    = 1'b0;
          word_d   = NOP_WORD;
        end
      end
      ST_SERVICE: begin
        if (reti) begin
          state_d  = ST_IDLE;
          active_d = 1'b0;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        sel_d    = 1'b0;
        word_d   = NOP_WORD;
        active_d = 1'b0;
      end
    endcase

    // A request landing on the bit being cleared keeps it set.
    pending_d = (pending_q & ~clr_mask) | hazard_req;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= 1'b0;
      word_q      <= NOP_WORD;
      active_q    <= 1'b0;
      active_id_q <= '0;
      pending_q   <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      word_q      <= word_d;
      active_q    <= active_d;
      active_id_q <= active_id_d;
      pending_q   <= pending_d;
    end
  end

  assign sel                     = sel_q;
  assign hazard_call_instruction = word_q;
  assign active                  = active_q;
  assign active_id               = active_id_q;
  assign pending                 = pending_q;

endmodule
`default_nettype wire
